// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state encoding and hold-counter sizing for the bus arbiter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2,
        TURN    = 2'd3
    } arbState_t;

    localparam int HOLD_W = 16;
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick: first set request at or above ptr, wrapping
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);

    // Scan from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                index = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared-bus arbiter with registered grant and hold watchdog
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_CORES    = 4,
    parameter int HOLD_LIMIT = 0,
    localparam int IDW       = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CORES-1:0] bus_rq,
    input  logic               bus_ready,
    output logic [N_CORES-1:0] bus_grant,
    output logic [IDW-1:0]     grant_id,
    output logic               bus_busy,
    output logic               hold_timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_LIMIT);

    arbState_t          state, nextState;
    logic [IDW-1:0]     ptr, ptrNext, grantIdNext;
    logic [N_CORES-1:0] grantNext;
    logic [HOLD_W-1:0]  holdCount, holdNext;
    logic               timeoutNext;
    logic               pickValid;
    logic [IDW-1:0]     pickIndex;

    rr_priority_picker #(
        .N  (N_CORES),
        .IW (IDW)
    ) picker (
        .req   (bus_rq),
        .ptr   (ptr),
        .valid (pickValid),
        .index (pickIndex)
    );

    assign bus_busy = (state != IDLE);

    always_comb begin
        nextState   = state;
        grantNext   = bus_grant;
        grantIdNext = grant_id;
        ptrNext     = ptr;
        holdNext    = holdCount;
        timeoutNext = 1'b0;
        case (state)
            IDLE: begin
                if (pickValid && !bus_ready) begin
                    nextState            = GRANT;
                    grantNext            = '0;
                    grantNext[pickIndex] = 1'b1;
                    grantIdNext          = pickIndex;
                    holdNext             = '0;
                end
            end
            GRANT: begin
                if (!bus_rq[grant_id]) begin
                    nextState = RELEASE;
                    grantNext = '0;
                    ptrNext   = (grant_id == IDW'(N_CORES - 1)) ? '0 : grant_id + 1'b1;
                end else begin
                    if (holdCount != HOLD_MAX)
                        holdNext = holdCount + 1'b1;
                    // Fire only on the transition into the limit so a saturated counter cannot re-trigger.
                    timeoutNext = (HOLD_LIMIT != 0) && (holdNext == HOLD_LIM) && (holdCount != HOLD_LIM);
                end
            end
            RELEASE: begin
                if (!bus_ready)
                    nextState = TURN;
            end
            TURN:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus_grant    <= '0;
            grant_id     <= '0;
            ptr          <= '0;
            holdCount    <= '0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= nextState;
            bus_grant    <= grantNext;
            grant_id     <= grantIdNext;
            ptr          <= ptrNext;
            holdCount    <= holdNext;
            hold_timeout <= timeoutNext;
        end
    end

endmodule
